// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display readers and decoders.
// Segment patterns are active-low, ordered abcdefg (bit6 = a, bit0 = g).
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  // All segments off; also the idle value of the sampled segment bus.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Nibble reported for any pattern that is not a decimal digit.
  localparam logic [3:0] NIBBLE_INVALID = 4'hF;

  // Frame assembly state: waiting for digit0, or collecting digits 1..3.
  typedef enum logic {
    WAIT0   = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to BCD decoder.
// Unknown patterns map to NIBBLE_INVALID and raise the invalid flag.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       invalid
);

  // Map the active-low abcdefg pattern to its decimal value.
  always_comb begin
    nibble  = NIBBLE_INVALID;
    invalid = 1'b0;
    case (pattern)
      SEG_0:   nibble = 4'd0;
      SEG_1:   nibble = 4'd1;
      SEG_2:   nibble = 4'd2;
      SEG_3:   nibble = 4'd3;
      SEG_4:   nibble = 4'd4;
      SEG_5:   nibble = 4'd5;
      SEG_6:   nibble = 4'd6;
      SEG_7:   nibble = 4'd7;
      SEG_8:   nibble = 4'd8;
      SEG_9:   nibble = 4'd9;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads a multiplexed 4-digit seven-segment display back into BCD.
// Each digit must be seen stable for STABLE_CYCLES samples before it is
// captured; digits 0..3 captured in order form one frame on VALUE.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FRAME_TIMEOUT = 1024
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [6:0]  SEG,
  input  logic [3:0]  DIG,
  output logic [15:0] VALUE,
  output logic        VALID,
  output logic        ERR,
  output logic        TIMEOUT,
  output state_t      fsm_state
);

  localparam int          TW         = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [3:0]  STABLE_MAX = 4'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(FRAME_TIMEOUT - 1);

  logic [6:0]    seg_q, seg_prev;
  logic [3:0]    dig_q, dig_prev;
  logic [3:0]    stable_cnt, stable_next;
  logic          capture;
  logic [1:0]    digit_idx;
  logic [3:0]    dec_nibble;
  logic          dec_invalid;

  state_t        state;
  logic [1:0]    expected;
  logic [3:0]    nib0, nib1, nib2;
  logic          err_acc;
  logic [TW-1:0] tmo_cnt;

  assign fsm_state = state;

  // Single input register stage plus the previous sample for comparison.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      seg_q    <= SEG_BLANK;
      dig_q    <= 4'd0;
      seg_prev <= SEG_BLANK;
      dig_prev <= 4'd0;
    end else begin
      seg_q    <= SEG;
      dig_q    <= DIG;
      seg_prev <= seg_q;
      dig_prev <= dig_q;
    end
  end

  // Stability count and capture decision; capture fires only on the step
  // into STABLE_MAX, so a long hold yields a single capture.
  always_comb begin
    stable_next = 4'd0;
    digit_idx   = 2'd0;
    if ($onehot(dig_q)) begin
      if (seg_q == seg_prev && dig_q == dig_prev) begin
        stable_next = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + 4'd1;
      end else begin
        stable_next = 4'd1;
      end
    end
    case (dig_q)
      4'b0010: digit_idx = 2'd1;
      4'b0100: digit_idx = 2'd2;
      4'b1000: digit_idx = 2'd3;
      default: digit_idx = 2'd0;
    endcase
    capture = (stable_next == STABLE_MAX) && (stable_cnt != STABLE_MAX);
  end

  // Stability counter register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) stable_cnt <= 4'd0;
    else       stable_cnt <= stable_next;
  end

  seg7_decode u_decode (
    .pattern (seg_q),
    .nibble  (dec_nibble),
    .invalid (dec_invalid)
  );

  // Frame assembly FSM with registered VALUE/ERR/VALID/TIMEOUT.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= WAIT0;
      expected <= 2'd0;
      nib0     <= 4'd0;
      nib1     <= 4'd0;
      nib2     <= 4'd0;
      err_acc  <= 1'b0;
      tmo_cnt  <= '0;
      VALUE    <= 16'hFFFF;
      ERR      <= 1'b0;
      VALID    <= 1'b0;
      TIMEOUT  <= 1'b0;
    end else begin
      VALID   <= 1'b0;
      TIMEOUT <= 1'b0;
      case (state)
        WAIT0: begin
          tmo_cnt <= '0;
          if (capture && digit_idx == 2'd0) begin
            nib0     <= dec_nibble;
            err_acc  <= dec_invalid;
            expected <= 2'd1;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (capture) begin
            // A capture on the timeout cycle takes priority over abandoning.
            tmo_cnt <= '0;
            if (digit_idx == 2'd0) begin
              nib0     <= dec_nibble;
              err_acc  <= dec_invalid;
              expected <= 2'd1;
            end else if (digit_idx == expected) begin
              if (digit_idx == 2'd3) begin
                VALUE    <= {dec_nibble, nib2, nib1, nib0};
                ERR      <= err_acc | dec_invalid;
                VALID    <= 1'b1;
                expected <= 2'd0;
                state    <= WAIT0;
              end else begin
                if (digit_idx == 2'd1) nib1 <= dec_nibble;
                else                   nib2 <= dec_nibble;
                err_acc  <= err_acc | dec_invalid;
                expected <= expected + 2'd1;
              end
            end else begin
              expected <= 2'd0;
              state    <= WAIT0;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt  <= '0;
            expected <= 2'd0;
            TIMEOUT  <= 1'b1;
            state    <= WAIT0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= WAIT0;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: table of display scans plus hand-written
// sequences for latency, non-one-hot select, timeout and mid-frame reset.
module tb_seg7_reader;
  import seg7_pkg::state_t;
  import seg7_pkg::WAIT0;
  import seg7_pkg::COLLECT;

  // Bench-local copies of the display patterns (active-low abcdefg).
  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] P6 = 7'b0100000;
  localparam logic [6:0] P7 = 7'b0001111;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100;
  localparam logic [6:0] PBAD = 7'b1111110;

  logic        CLOCK_50;
  logic        reset;
  logic [6:0]  SEG;
  logic [3:0]  DIG;
  logic [15:0] VALUE;
  logic        VALID;
  logic        ERR;
  logic        TIMEOUT;
  state_t      fsm_state;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int to_cnt    = 0;

  seg7_reader #(.STABLE_CYCLES(4), .FRAME_TIMEOUT(1024)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .SEG       (SEG),
    .DIG       (DIG),
    .VALUE     (VALUE),
    .VALID     (VALID),
    .ERR       (ERR),
    .TIMEOUT   (TIMEOUT),
    .fsm_state (fsm_state)
  );

  // Clock and watchdog.
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  // Pulse monitor, sampled on the falling edge.
  always @(negedge CLOCK_50) begin
    if (VALID === 1'b1)   valid_cnt++;
    if (TIMEOUT === 1'b1) to_cnt++;
  end

  typedef struct {
    string           name;
    logic [3:0][6:0] segs;   // pattern for each digit position
    logic [3:0][1:0] order;  // digit position visited at each step
    int              hold;
    int              exp_valid;
    logic [15:0]     exp_value;
    logic            exp_err;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(string name, logic [6:0] s0, logic [6:0] s1,
                              logic [6:0] s2, logic [6:0] s3, logic [7:0] order,
                              int hold, int ev, logic [15:0] val, logic e);
    vec_t v;
    v.name      = name;
    v.segs      = {s3, s2, s1, s0};
    v.order     = order;
    v.hold      = hold;
    v.exp_valid = ev;
    v.exp_value = val;
    v.exp_err   = e;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Advance n sampling edges, leaving the bench 1ns after the last edge.
  task automatic step(int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic show(logic [6:0] s, int digit, int n);
    SEG = s;
    DIG = 4'b0001 << digit;
    step(n);
  endtask

  task automatic idle(int n);
    SEG = 7'h7F;
    DIG = 4'd0;
    step(n);
  endtask

  task automatic run_scan(vec_t v);
    int d;
    for (int i = 0; i < 4; i++) begin
      d = int'(v.order[i]);
      show(v.segs[d], d, v.hold);
    end
    idle(6);
  endtask

  initial begin
    int v0, t0, to_seen, to_at;
    logic [15:0] keep;

    vecs[0] = mk("short_hold",   P1, P2, P3,   P4, 8'hE4, 3, 0, 16'hFFFF, 1'b0);
    vecs[1] = mk("scan_4321",    P1, P2, P3,   P4, 8'hE4, 8, 1, 16'h4321, 1'b0);
    vecs[2] = mk("bad_digit2",   P1, P2, PBAD, P4, 8'hE4, 8, 1, 16'h4F21, 1'b1);
    vecs[3] = mk("out_of_order", P5, P6, P7,   P8, 8'hD8, 8, 0, 16'h4F21, 1'b1);
    vecs[4] = mk("scan_8765",    P5, P6, P7,   P8, 8'hE4, 8, 1, 16'h8765, 1'b0);
    vecs[5] = mk("scan_7809",    P9, P0, P8,   P7, 8'hE4, 8, 1, 16'h7809, 1'b0);
    vecs[6] = mk("min_hold",     P2, P5, P8,   P1, 8'hE4, 4, 1, 16'h1852, 1'b0);

    // Reset state.
    reset = 1'b1;
    SEG   = 7'h7F;
    DIG   = 4'd0;
    @(posedge CLOCK_50); #1;
    step(3);
    check("reset_value",   VALUE,   16'hFFFF);
    check("reset_valid",   VALID,   1'b0);
    check("reset_err",     ERR,     1'b0);
    check("reset_timeout", TIMEOUT, 1'b0);
    check("reset_state",   fsm_state, WAIT0);
    reset = 1'b0;
    step(2);

    // Table-driven scans.
    foreach (vecs[i]) begin
      v0 = valid_cnt;
      run_scan(vecs[i]);
      check({vecs[i].name, "_valid"}, valid_cnt - v0, vecs[i].exp_valid);
      check({vecs[i].name, "_value"}, VALUE, vecs[i].exp_value);
      check({vecs[i].name, "_err"},   ERR,   vecs[i].exp_err);
    end
    check("no_stray_timeout", to_cnt, 0);

    // Latency: digit3 first sampled at edge k gives VALID after edge k+4.
    show(P3, 0, 8);
    show(P0, 1, 8);
    show(P5, 2, 8);
    SEG = P9;
    DIG = 4'b1000;
    for (int n = 1; n <= 8; n++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check($sformatf("latency_n%0d", n), VALID, (n == 5) ? 1'b1 : 1'b0);
    end
    @(posedge CLOCK_50); #1;
    idle(4);
    check("latency_value", VALUE, 16'h9503);

    // Non-one-hot selects in mid-frame must neither capture nor break it.
    v0 = valid_cnt;
    show(P6, 0, 8);
    show(P9, 1, 8);
    SEG = P7; DIG = 4'b0011; step(10);
    SEG = P7; DIG = 4'b0110; step(10);
    show(P1, 2, 8);
    show(P2, 3, 8);
    idle(6);
    check("nonhot_valid", valid_cnt - v0, 1);
    check("nonhot_value", VALUE, 16'h2196);

    // Timeout: digit0 captured, then idle; pulse after 1024 idle cycles.
    v0 = valid_cnt;
    t0 = to_cnt;
    keep = VALUE;
    to_seen = 0;
    to_at = 0;
    SEG = P1;
    DIG = 4'b0001;
    for (int n = 1; n <= 1100; n++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (TIMEOUT === 1'b1) begin
        to_seen++;
        to_at = n;
      end
      if (n == 8) begin
        SEG = 7'h7F;
        DIG = 4'd0;
      end
      if (n == 10) check("timeout_collecting", fsm_state, COLLECT);
    end
    @(posedge CLOCK_50); #1;
    check("timeout_pulses", to_seen, 1);
    check("timeout_cycle",  to_at, 1029);
    check("timeout_monitor", to_cnt - t0, 1);
    check("timeout_no_valid", valid_cnt - v0, 0);
    check("timeout_value", VALUE, keep);
    check("timeout_state", fsm_state, WAIT0);

    // Reset after digit2 capture discards the frame.
    v0 = valid_cnt;
    show(P1, 0, 8);
    show(P2, 1, 8);
    show(P3, 2, 8);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    show(P4, 3, 8);
    idle(6);
    check("midreset_valid", valid_cnt - v0, 0);
    check("midreset_value", VALUE, 16'hFFFF);
    check("midreset_err",   ERR,   1'b0);
    check("midreset_state", fsm_state, WAIT0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
